// File: rtl/ex_mdu_pkg.sv
// rtl/ex_mdu_pkg.sv - RV32M decode constants, MDU state encoding and func3 helpers
package ex_mdu_pkg;

  localparam logic [6:0] INST_FUNC7_M = 7'b0000001;

  localparam logic [2:0] INST_MUL    = 3'b000;
  localparam logic [2:0] INST_MULH   = 3'b001;
  localparam logic [2:0] INST_MULHSU = 3'b010;
  localparam logic [2:0] INST_MULHU  = 3'b011;
  localparam logic [2:0] INST_DIV    = 3'b100;
  localparam logic [2:0] INST_DIVU   = 3'b101;
  localparam logic [2:0] INST_REM    = 3'b110;
  localparam logic [2:0] INST_REMU   = 3'b111;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DIV  = 2'd2,
    S_DONE = 2'd3
  } mdu_state_e;

  // Divide/remainder group: func3[2] set.
  function automatic logic is_div_op(input logic [2:0] f3);
    return f3[2];
  endfunction

  // DIV and REM are signed; the U variants have func3[0] set.
  function automatic logic is_signed_div(input logic [2:0] f3);
    return ~f3[0];
  endfunction

endpackage

// File: rtl/mdu_div_core.sv
// rtl/mdu_div_core.sv - iterative unsigned restoring divider, DIV_BITS quotient bits per cycle
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   start_i             load dividend/divisor and begin iterating
//   kill_i              abandon the division in progress
//   dividend_i          unsigned dividend
//   divisor_i           unsigned divisor (never zero; the caller handles that case)
//   busy_o              iterations still outstanding
//   done_o              one-cycle pulse, quotient/remainder valid
//   quotient_o          unsigned quotient
//   remainder_o         unsigned remainder
module mdu_div_core #(
  parameter int XLEN     = 32,
  parameter int DIV_BITS = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start_i,
  input  logic            kill_i,
  input  logic [XLEN-1:0] dividend_i,
  input  logic [XLEN-1:0] divisor_i,
  output logic            busy_o,
  output logic            done_o,
  output logic [XLEN-1:0] quotient_o,
  output logic [XLEN-1:0] remainder_o
);

  localparam int ITERS = XLEN / DIV_BITS;
  localparam int CNT_W = $clog2(ITERS + 1);

  logic [XLEN-1:0]  quo_q, rem_q, dsr_q;
  logic [CNT_W-1:0] cnt_q;
  logic             busy_q, done_q;

  logic [XLEN-1:0]  quo_n, rem_n;
  logic [XLEN:0]    trial;

  // quo_q doubles as the dividend shift register: its MSB feeds the partial
  // remainder while quotient bits fill in from the bottom.
  always_comb begin
    quo_n = quo_q;
    rem_n = rem_q;
    trial = '0;
    for (int i = 0; i < DIV_BITS; i++) begin
      trial = {rem_n, quo_n[XLEN-1]};
      quo_n = {quo_n[XLEN-2:0], 1'b0};
      if (trial >= {1'b0, dsr_q}) begin
        trial    = trial - {1'b0, dsr_q};
        quo_n[0] = 1'b1;
      end
      rem_n = trial[XLEN-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      quo_q  <= '0;
      rem_q  <= '0;
      dsr_q  <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (start_i) begin
        quo_q  <= dividend_i;
        rem_q  <= '0;
        dsr_q  <= divisor_i;
        cnt_q  <= CNT_W'(ITERS);
        busy_q <= 1'b1;
      end else if (kill_i) begin
        cnt_q  <= '0;
        busy_q <= 1'b0;
      end else if (busy_q) begin
        quo_q <= quo_n;
        rem_q <= rem_n;
        cnt_q <= cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          busy_q <= 1'b0;
          done_q <= 1'b1;
        end
      end
    end
  end

  assign busy_o      = busy_q;
  assign done_o      = done_q;
  assign quotient_o  = quo_q;
  assign remainder_o = rem_q;

endmodule

// File: rtl/ex_mdu.sv
// rtl/ex_mdu.sv - multi-cycle RV32M multiply/divide unit beside the execute stage
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   start_i             launch an op (sampled only in IDLE)
//   func3_i             M-extension op select
//   op1_i, op2_i        rs1 / rs2 values
//   rd_addr_i           destination register
//   flush_i             jump from ctrl; kills the op in flight
//   hold_flag_o         stall request to ctrl
//   rd_addr_o           write-back address
//   rd_data_o           write-back data
//   rd_wen_o            write-back enable, one-cycle pulse
module ex_mdu
  import ex_mdu_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter int MUL_STAGES = 2,
  parameter int DIV_BITS   = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start_i,
  input  logic [2:0]      func3_i,
  input  logic [XLEN-1:0] op1_i,
  input  logic [XLEN-1:0] op2_i,
  input  logic [4:0]      rd_addr_i,
  input  logic            flush_i,
  output logic            hold_flag_o,
  output logic [4:0]      rd_addr_o,
  output logic [XLEN-1:0] rd_data_o,
  output logic            rd_wen_o
);

  localparam logic [XLEN-1:0] MIN_NEG  = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [1:0]      MUL_LAST = 2'(MUL_STAGES - 1);

  mdu_state_e      state_q, state_d;
  logic [2:0]      func3_q;
  logic [XLEN-1:0] op1_q, op2_q;
  logic [4:0]      rd_addr_q;
  logic [1:0]      mcnt_q, mcnt_d;
  logic [XLEN-1:0] wb_data_q, wb_data_d;
  logic [4:0]      wb_addr_q, wb_addr_d;

  // ---------------- launch decode (from live inputs) ----------------
  logic            launch, sdiv_i, div_zero, div_ovf, special, div_start;
  logic [XLEN-1:0] spec_res, dvd_abs, dsr_abs;

  assign launch   = start_i && (state_q == S_IDLE) && !flush_i;
  assign sdiv_i   = is_signed_div(func3_i);
  assign div_zero = (op2_i == '0);
  assign div_ovf  = sdiv_i && (op1_i == MIN_NEG) && (op2_i == '1);
  assign special  = is_div_op(func3_i) && (div_zero || div_ovf);

  // func3[1] selects remainder over quotient.
  always_comb begin
    if (func3_i[1]) spec_res = div_zero ? op1_i : '0;
    else            spec_res = div_zero ? '1    : op1_i;
  end

  assign dvd_abs   = (sdiv_i && op1_i[XLEN-1]) ? -op1_i : op1_i;
  assign dsr_abs   = (sdiv_i && op2_i[XLEN-1]) ? -op2_i : op2_i;
  assign div_start = launch && is_div_op(func3_i) && !special;

  // ---------------- multiply datapath ----------------
  logic              a_sgn, b_sgn;
  logic [XLEN:0]     a_ext, b_ext;
  logic [2*XLEN-1:0] a_w, b_w, prod, mul_res;
  logic [XLEN-1:0]   mul_half;

  assign a_sgn = (func3_q != INST_MULHU);
  assign b_sgn = (func3_q == INST_MUL) || (func3_q == INST_MULH);
  assign a_ext = {a_sgn & op1_q[XLEN-1], op1_q};
  assign b_ext = {b_sgn & op2_q[XLEN-1], op2_q};
  assign a_w   = {{(XLEN-1){a_ext[XLEN]}}, a_ext};
  assign b_w   = {{(XLEN-1){b_ext[XLEN]}}, b_ext};
  assign prod  = a_w * b_w;

  // The write-back register is the last multiply stage, so only
  // MUL_STAGES-1 pipeline registers sit between the operands and it.
  generate
    if (MUL_STAGES == 1) begin : g_mul_comb
      assign mul_res = prod;
    end else begin : g_mul_pipe
      logic [2*XLEN-1:0] pipe_q [MUL_STAGES-1];
      always_ff @(posedge clk) begin
        if (rst) begin
          for (int i = 0; i < MUL_STAGES - 1; i++) pipe_q[i] <= '0;
        end else begin
          pipe_q[0] <= prod;
          for (int i = 1; i < MUL_STAGES - 1; i++) pipe_q[i] <= pipe_q[i-1];
        end
      end
      assign mul_res = pipe_q[MUL_STAGES-2];
    end
  endgenerate

  assign mul_half = (func3_q == INST_MUL) ? mul_res[XLEN-1:0] : mul_res[2*XLEN-1:XLEN];

  // ---------------- divide datapath ----------------
  logic            div_busy, div_done, q_neg, r_neg;
  logic [XLEN-1:0] div_quo, div_rem, div_res;

  mdu_div_core #(
    .XLEN     (XLEN),
    .DIV_BITS (DIV_BITS)
  ) u_div (
    .clk         (clk),
    .rst         (rst),
    .start_i     (div_start),
    .kill_i      (flush_i),
    .dividend_i  (dvd_abs),
    .divisor_i   (dsr_abs),
    .busy_o      (div_busy),
    .done_o      (div_done),
    .quotient_o  (div_quo),
    .remainder_o (div_rem)
  );

  assign q_neg   = is_signed_div(func3_q) && (op1_q[XLEN-1] ^ op2_q[XLEN-1]);
  assign r_neg   = is_signed_div(func3_q) && op1_q[XLEN-1];
  assign div_res = func3_q[1] ? (r_neg ? -div_rem : div_rem)
                              : (q_neg ? -div_quo : div_quo);

  // ---------------- control ----------------
  always_comb begin
    state_d   = state_q;
    mcnt_d    = mcnt_q;
    wb_data_d = wb_data_q;
    wb_addr_d = wb_addr_q;
    case (state_q)
      S_IDLE: begin
        if (launch) begin
          if (!is_div_op(func3_i)) begin
            state_d = S_MUL;
            mcnt_d  = '0;
          end else if (special) begin
            state_d   = S_DONE;
            wb_data_d = spec_res;
            wb_addr_d = rd_addr_i;
          end else begin
            state_d = S_DIV;
          end
        end
      end
      S_MUL: begin
        if (flush_i) begin
          state_d = S_IDLE;
        end else if (mcnt_q == MUL_LAST) begin
          state_d   = S_DONE;
          wb_data_d = mul_half;
          wb_addr_d = rd_addr_q;
        end else begin
          mcnt_d = mcnt_q + 2'd1;
        end
      end
      S_DIV: begin
        if (flush_i) begin
          state_d = S_IDLE;
        end else if (div_done && !div_busy) begin
          // Sign-fix cycle: unsigned result is ready, correct and write back.
          state_d   = S_DONE;
          wb_data_d = div_res;
          wb_addr_d = rd_addr_q;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      func3_q   <= '0;
      op1_q     <= '0;
      op2_q     <= '0;
      rd_addr_q <= '0;
      mcnt_q    <= '0;
      wb_data_q <= '0;
      wb_addr_q <= '0;
    end else begin
      state_q   <= state_d;
      mcnt_q    <= mcnt_d;
      wb_data_q <= wb_data_d;
      wb_addr_q <= wb_addr_d;
      if (launch) begin
        func3_q   <= func3_i;
        op1_q     <= op1_i;
        op2_q     <= op2_i;
        rd_addr_q <= rd_addr_i;
      end
    end
  end

  // Combinational from start_i so ex stalls in the launch cycle; low in DONE
  // so the pipeline advances while the result writes back.
  assign hold_flag_o = !rst && ((start_i && state_q == S_IDLE) ||
                                state_q == S_MUL || state_q == S_DIV);
  assign rd_wen_o    = (state_q == S_DONE);
  assign rd_data_o   = wb_data_q;
  assign rd_addr_o   = wb_addr_q;

endmodule
